// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared encodings and constants for the fetch stage
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_SEL_INC   = 2'd0,
        PC_SEL_REDIR = 2'd1,
        PC_SEL_TGT   = 2'd2
    } pc_sel_e;

    localparam logic [15:0] DEFAULT_NOP_INSTR = 16'h0800;
    localparam logic [15:0] PC_INC            = 16'd2;

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - single-bit register cell with synchronous reset and enable
module dff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= RST_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/dff_16.sv
// rtl/dff_16.sv - 16-bit register cell with synchronous reset and enable
module dff_16 #(
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [15:0] d_i,
    output logic [15:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= RST_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/fetch_stage_fsm.sv
// rtl/fetch_stage_fsm.sv - fetch control: state/squash registers and datapath enables
module fetch_fsm
    import fetch_stage_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         stall_i,
    input  logic         redirect_i,
    input  logic         halt_i,
    input  logic         imem_done_i,
    output fetch_state_e state_o,
    output logic         pc_load_o,
    output pc_sel_e      pc_sel_o,
    output logic         buf_load_o,
    output logic         tgt_load_o,
    output logic         use_buf_o,
    output logic         fetch_valid_o,
    output logic         imem_rd_o
);

    fetch_state_e state_q, state_d;
    logic [1:0]   state_bits_q;
    logic [1:0]   state_bits_d;
    logic         squash_q, squash_d;

    assign state_q      = fetch_state_e'(state_bits_q);
    assign state_bits_d = state_d;
    assign state_o      = state_q;

    dff #(.RST_VAL(1'b0)) u_state0 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1), .d_i(state_bits_d[0]), .q_o(state_bits_q[0])
    );
    dff #(.RST_VAL(1'b0)) u_state1 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1), .d_i(state_bits_d[1]), .q_o(state_bits_q[1])
    );
    dff #(.RST_VAL(1'b0)) u_squash (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1), .d_i(squash_d), .q_o(squash_q)
    );

    always_comb begin
        state_d       = state_q;
        squash_d      = squash_q;
        pc_load_o     = 1'b0;
        pc_sel_o      = PC_SEL_INC;
        buf_load_o    = 1'b0;
        tgt_load_o    = 1'b0;
        use_buf_o     = 1'b0;
        fetch_valid_o = 1'b0;
        imem_rd_o     = 1'b0;

        unique case (state_q)
            ST_REQ, ST_WAIT: begin
                imem_rd_o = 1'b1;
                if (redirect_i) begin
                    if (imem_done_i) begin
                        pc_load_o = 1'b1;
                        pc_sel_o  = PC_SEL_REDIR;
                        squash_d  = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        // read in flight cannot be cancelled; remember where to go
                        tgt_load_o = 1'b1;
                        squash_d   = 1'b1;
                        state_d    = ST_WAIT;
                    end
                end else if (halt_i) begin
                    imem_rd_o = 1'b0;
                    squash_d  = 1'b0;
                    state_d   = ST_HALTED;
                end else if (squash_q) begin
                    if (imem_done_i) begin
                        pc_load_o = 1'b1;
                        pc_sel_o  = PC_SEL_TGT;
                        squash_d  = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (imem_done_i) begin
                    fetch_valid_o = 1'b1;
                    if (stall_i) begin
                        buf_load_o = 1'b1;
                        state_d    = ST_HOLD;
                    end else begin
                        pc_load_o = 1'b1;
                        state_d   = ST_REQ;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                use_buf_o = 1'b1;
                if (redirect_i) begin
                    pc_load_o = 1'b1;
                    pc_sel_o  = PC_SEL_REDIR;
                    state_d   = ST_REQ;
                end else if (halt_i) begin
                    state_d = ST_HALTED;
                end else begin
                    fetch_valid_o = 1'b1;
                    if (!stall_i) begin
                        pc_load_o = 1'b1;
                        state_d   = ST_REQ;
                    end
                end
            end
            default: ;
        endcase

        if (rst_i) begin
            fetch_valid_o = 1'b0;
            imem_rd_o     = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem handshake, hold buffer, redirects
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2_out,
    output logic        fetch_valid,
    output logic        err
);

    fetch_state_e state;
    pc_sel_e      pc_sel;
    logic         pc_load, buf_load, tgt_load, use_buf;
    logic [15:0]  pc_q, pc_d, tgt_q, buf_q;

    fetch_fsm u_fsm (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .halt_i       (halt),
        .imem_done_i  (imem_done),
        .state_o      (state),
        .pc_load_o    (pc_load),
        .pc_sel_o     (pc_sel),
        .buf_load_o   (buf_load),
        .tgt_load_o   (tgt_load),
        .use_buf_o    (use_buf),
        .fetch_valid_o(fetch_valid),
        .imem_rd_o    (imem_rd)
    );

    always_comb begin
        pc_d = pc_q + PC_INC;
        unique case (pc_sel)
            PC_SEL_REDIR: pc_d = redirect_pc;
            PC_SEL_TGT:   pc_d = tgt_q;
            default:      pc_d = pc_q + PC_INC;
        endcase
    end

    dff_16 #(.RST_VAL(RESET_PC)) u_pc (
        .clk_i(clk), .rst_i(rst), .en_i(pc_load), .d_i(pc_d), .q_o(pc_q)
    );
    dff_16 #(.RST_VAL(16'h0000)) u_tgt (
        .clk_i(clk), .rst_i(rst), .en_i(tgt_load), .d_i(redirect_pc), .q_o(tgt_q)
    );
    dff_16 #(.RST_VAL(16'h0000)) u_buf (
        .clk_i(clk), .rst_i(rst), .en_i(buf_load), .d_i(imem_data), .q_o(buf_q)
    );

    assign imem_addr    = pc_q;
    assign pc_plus2_out = pc_q + PC_INC;
    assign instr_out    = !fetch_valid ? NOP_INSTR : (use_buf ? buf_q : imem_data);
    assign err          = !rst && (state != ST_HALTED) && pc_q[0];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, halt, imem_done;
    logic [15:0] redirect_pc, imem_data;
    logic        imem_rd, fetch_valid, err;
    logic [15:0] imem_addr, instr_out, pc_plus2_out;

    int total = 0;
    int bad   = 0;

    localparam logic [15:0] NOP = 16'h0800;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
        .imem_done(imem_done), .instr_out(instr_out), .pc_plus2_out(pc_plus2_out),
        .fetch_valid(fetch_valid), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, redir;
        logic [15:0] rpc;
        logic        halt, done;
        logic [15:0] data;
        logic        e_rd;
        logic [15:0] e_addr, e_instr, e_p2;
        logic        e_fv, e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic rd_, input logic [15:0] rpc,
                       input logic h, input logic d, input logic [15:0] dat,
                       input logic erd, input logic [15:0] eaddr, input logic [15:0] einstr,
                       input logic [15:0] ep2, input logic efv, input logic eerr);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = rd_; v.rpc = rpc; v.halt = h; v.done = d; v.data = dat;
        v.e_rd = erd; v.e_addr = eaddr; v.e_instr = einstr; v.e_p2 = ep2; v.e_fv = efv; v.e_err = eerr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rd_, input logic [15:0] rpc,
                         input logic h, input logic d, input logic [15:0] dat);
        @(negedge clk);
        rst = r; stall = s; redirect = rd_; redirect_pc = rpc; halt = h; imem_done = d; imem_data = dat;
        #2;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
        imem_done = 1'b0; imem_data = 16'h0;
        @(posedge clk);
        @(posedge clk);

        //   rst stl red rpc      hlt dn data       rd addr     instr     p2        fv err
        add(1, 0, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0000, NOP,      16'h0002, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h1111,  1, 16'h0000, 16'h1111, 16'h0002, 1, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h2222,  1, 16'h0002, 16'h2222, 16'h0004, 1, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h3333,  1, 16'h0004, 16'h3333, 16'h0006, 1, 0);
        add(1, 0, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0006, NOP,      16'h0008, 0, 0);
        // slow memory: three empty cycles at address 0
        add(0, 0, 0, 16'h0000, 0, 0, 16'h9999,  1, 16'h0000, NOP,      16'h0002, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 0, 16'h9999,  1, 16'h0000, NOP,      16'h0002, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 0, 16'h9999,  1, 16'h0000, NOP,      16'h0002, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h1111,  1, 16'h0000, 16'h1111, 16'h0002, 1, 0);
        // stall into HOLD, two stalled cycles then release
        add(0, 1, 0, 16'h0000, 0, 1, 16'h2222,  1, 16'h0002, 16'h2222, 16'h0004, 1, 0);
        add(0, 1, 0, 16'h0000, 0, 0, 16'h9999,  0, 16'h0002, 16'h2222, 16'h0004, 1, 0);
        add(0, 0, 0, 16'h0000, 0, 0, 16'h9999,  0, 16'h0002, 16'h2222, 16'h0004, 1, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h3333,  1, 16'h0004, 16'h3333, 16'h0006, 1, 0);
        // redirect while waiting at 6, late data squashed
        add(0, 0, 0, 16'h0000, 0, 0, 16'h9999,  1, 16'h0006, NOP,      16'h0008, 0, 0);
        add(0, 0, 1, 16'h0040, 0, 0, 16'h9999,  1, 16'h0006, NOP,      16'h0008, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h4444,  1, 16'h0006, NOP,      16'h0008, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h5555,  1, 16'h0040, 16'h5555, 16'h0042, 1, 0);
        // redirect with data arriving: data dropped, jump to FFFE and wrap
        add(0, 0, 1, 16'hFFFE, 0, 1, 16'h6666,  1, 16'h0042, NOP,      16'h0044, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h7777,  1, 16'hFFFE, 16'h7777, 16'h0000, 1, 0);
        // halt, redirect ignored while halted
        add(0, 0, 0, 16'h0000, 1, 0, 16'h9999,  0, 16'h0000, NOP,      16'h0002, 0, 0);
        add(0, 0, 1, 16'h0080, 0, 1, 16'h8888,  0, 16'h0000, NOP,      16'h0002, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h8888,  0, 16'h0000, NOP,      16'h0002, 0, 0);
        add(1, 0, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0000, NOP,      16'h0002, 0, 0);
        // odd redirect target raises err once loaded
        add(0, 0, 1, 16'h0041, 0, 1, 16'h1234,  1, 16'h0000, NOP,      16'h0002, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h2345,  1, 16'h0041, 16'h2345, 16'h0043, 1, 1);
        add(0, 0, 0, 16'h0000, 0, 0, 16'h9999,  1, 16'h0043, NOP,      16'h0045, 0, 1);
        // reset lands on the same edge as the pending read completing
        add(1, 0, 0, 16'h0000, 0, 1, 16'h3456,  0, 16'h0043, NOP,      16'h0045, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 0, 16'h9999,  1, 16'h0000, NOP,      16'h0002, 0, 0);
        // redirect out of HOLD discards the buffer
        add(0, 1, 0, 16'h0000, 0, 1, 16'hAAAA,  1, 16'h0000, 16'hAAAA, 16'h0002, 1, 0);
        add(0, 1, 1, 16'h0100, 0, 0, 16'h9999,  0, 16'h0000, NOP,      16'h0002, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'hBBBB,  1, 16'h0100, 16'hBBBB, 16'h0102, 1, 0);
        // two redirects while squashing: youngest target wins
        add(0, 0, 0, 16'h0000, 0, 0, 16'h9999,  1, 16'h0102, NOP,      16'h0104, 0, 0);
        add(0, 0, 1, 16'h0200, 0, 0, 16'h9999,  1, 16'h0102, NOP,      16'h0104, 0, 0);
        add(0, 0, 1, 16'h0300, 0, 0, 16'h9999,  1, 16'h0102, NOP,      16'h0104, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'hCCCC,  1, 16'h0102, NOP,      16'h0104, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'hDDDD,  1, 16'h0300, 16'hDDDD, 16'h0302, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc,
                  vecs[i].halt, vecs[i].done, vecs[i].data);
            check($sformatf("v%0d.imem_rd", i),     {15'h0, imem_rd},     {15'h0, vecs[i].e_rd});
            check($sformatf("v%0d.imem_addr", i),   imem_addr,            vecs[i].e_addr);
            check($sformatf("v%0d.instr_out", i),   instr_out,            vecs[i].e_instr);
            check($sformatf("v%0d.pc_plus2", i),    pc_plus2_out,         vecs[i].e_p2);
            check($sformatf("v%0d.fetch_valid", i), {15'h0, fetch_valid}, {15'h0, vecs[i].e_fv});
            check($sformatf("v%0d.err", i),         {15'h0, err},         {15'h0, vecs[i].e_err});
        end

        // halt while a read is outstanding: the read is dropped and never presented
        drive(1, 0, 0, 16'h0, 0, 0, 16'h0);
        drive(0, 0, 0, 16'h0, 0, 0, 16'h9999);
        drive(0, 0, 0, 16'h0, 0, 0, 16'h9999);
        check("wait_halt.imem_rd", {15'h0, imem_rd}, 16'h0001);
        drive(0, 0, 0, 16'h0, 1, 0, 16'h9999);
        check("halt_cyc.imem_rd", {15'h0, imem_rd}, 16'h0000);
        check("halt_cyc.valid",   {15'h0, fetch_valid}, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 16'h0, 0, 1, 16'hEEEE);
            check($sformatf("halted%0d.imem_rd", k), {15'h0, imem_rd}, 16'h0000);
            check($sformatf("halted%0d.valid", k),   {15'h0, fetch_valid}, 16'h0000);
            check($sformatf("halted%0d.instr", k),   instr_out, NOP);
            check($sformatf("halted%0d.addr", k),    imem_addr, 16'h0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage 16-bit pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC register and drives the instruction-memory read handshake.
- Handles decode stalls (one-entry hold buffer), branch/jump redirects (including squash of an in-flight fetch) and halt.
- Presents instruction, PC+2 and valid to IF/ID each cycle; invalid slots carry NOP.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, encoding driven on instr_out whenever fetch_valid=0.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall from decode; IF/ID is holding.
- redirect  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  16  target PC for redirect.
- halt  in  1  HALT decoded downstream; freeze fetch.
- imem_rd  out  1  instruction-memory read request.
- imem_addr  out  16  read address (= PC).
- imem_data  in  16  read data, valid when imem_done=1.
- imem_done  in  1  read complete this cycle.
- instr_out  out  16  instruction to IF/ID.
- pc_plus2_out  out  16  PC+2 of the presented instruction, to IF/ID.
- fetch_valid  out  1  instr_out is a real instruction.
- err  out  1  misaligned PC (pc[0]=1).

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - Registers: pc=RESET_PC, state=REQ, squash=0, tgt=0, buf=0.
  - While rst=1: imem_rd=0, fetch_valid=0, instr_out=NOP_INSTR, err=0.
  - rst overrides everything, including mid-WAIT; the abandoned memory read is ignored.
- States:
  - REQ: imem_rd=1, imem_addr=pc.
  - WAIT: imem_rd=1, imem_addr=pc held stable until done.
  - HOLD: imem_rd=0, instr_out=buf, fetch_valid=1.
  - HALTED: imem_rd=0, fetch_valid=0, NOP out.
- Per-cycle priority: rst > redirect > halt > imem_done/stall > idle.
- Outputs to IF/ID are combinational from the current state and imem_data, so single-cycle memory gives one instruction per cycle.
- REQ/WAIT with imem_done=1 and squash=0:
  - instr_out=imem_data, fetch_valid=1, pc_plus2_out=pc+2.
  - stall=0: pc<=pc+2, next state REQ.
  - stall=1: buf<=imem_data, next state HOLD, pc unchanged.
- REQ/WAIT with imem_done=0: fetch_valid=0, NOP out, next state WAIT.
- redirect in REQ/WAIT:
  - imem_done=1: discard data (fetch_valid=0), pc<=redirect_pc, next state REQ.
  - imem_done=0: read cannot be cancelled; tgt<=redirect_pc, squash<=1, next state WAIT.
- WAIT with squash=1 and imem_done=1: discard data, pc<=tgt, squash<=0, next state REQ. A later redirect while squash=1 overwrites tgt (youngest target wins).
- HOLD:
  - stall=0: pc<=pc+2, next state REQ; buf is presented this cycle, so IF/ID captures it.
  - stall=1: remain in HOLD, outputs stable.
  - redirect: discard buf, fetch_valid=0, pc<=redirect_pc, next state REQ.
- halt (with no redirect the same cycle): next state HALTED, fetch_valid=0. In WAIT, the outstanding read is dropped. HALTED exits only on rst; redirect is ignored in HALTED.
- Arithmetic:
  - PC increments by 2, modulo 2^16: 16'hFFFE -> 16'h0000.
  - pc_plus2_out wraps the same way.
  - redirect_pc is loaded unmodified.
- err = pc[0] in REQ/WAIT/HOLD, else 0. An odd redirect target raises err the cycle after load; the fetch still proceeds.

Decomposition:
- Shared package (pipeline package):
  - state encoding: REQ, WAIT, HOLD, HALTED as a 2-bit enum.
  - NOP_INSTR constant.
  - PC_INC=2.
- Registers are built from the existing dff_16 (pc, tgt, buf) and dff (state, squash) cells.
- One natural sub-module, fetch_fsm: holds state/squash and the next-state logic, and emits pc_load/pc_sel/buf_load.
- The top level holds the datapath muxes.

Test Plan:
- rst 1 cycle; single-cycle memory returns 16'h1111, 16'h2222, 16'h3333 -> imem_addr 0,2,4; instr_out matches each cycle, fetch_valid=1, pc_plus2_out 2,4,6.
- imem_done delayed 3 cycles at addr 0 -> fetch_valid=0 with NOP for 3 cycles, imem_addr held at 0, then 16'h1111 valid and pc=2.
- stall=1 for 2 cycles when 16'h2222 is returned at addr 2 -> HOLD, instr_out=16'h2222 for 3 cycles, imem_rd=0; stall drops -> next request at addr 4.
- redirect to 16'h0040 during WAIT at addr 6 -> late data at addr 6 discarded (fetch_valid=0), next imem_addr=16'h0040.
- pc=16'hFFFE with hit -> pc_plus2_out=16'h0000, next imem_addr=16'h0000. Then halt=1 -> imem_rd=0, fetch_valid=0, stays HALTED until rst.
- redirect to 16'h0041 -> err=1 next cycle. rst asserted in the same cycle as imem_done -> pc=RESET_PC, state REQ, data ignored.
